tilt_move_gen: RTL

TILT_MOVE_GEN -- requirements
Module: tilt_move_gen

---
 rtl/tilt_move_gen_if.sv | 20 ++
 rtl/tilt_move_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tilt_move_gen_if.sv
// Tilt sample input and ball-control outputs of tilt_move_gen.
// Handshake: accel_x/accel_y are meaningful only in a cycle with sample_valid=1; there is no ready.
interface tilt_move_gen_if;
    logic [7:0] accel_x;
    logic [7:0] accel_y;
    logic       sample_valid;
    logic [3:0] movement;
    logic       update;
    logic [1:0] tilt_level;

    modport master (
        output accel_x, accel_y, sample_valid,
        input  movement, update, tilt_level
    );

    modport slave (
        input  accel_x, accel_y, sample_valid,
        output movement, update, tilt_level
    );
endinterface

// File: rtl/tilt_move_gen.sv
// Turns accelerometer tilt samples into a debounced single-axis ball direction
// and a speed-scaled free-running update square wave.
module tilt_move_gen #(
    parameter int CLK_FREQUENCY_HZ     = 100000000,
    parameter int BASE_UPDATE_HZ       = 2000,
    parameter int DEADZONE             = 16,
    parameter int SIMULATE             = 0,
    parameter int SIMULATE_HALF_PERIOD = 4
) (
    input  logic            clk,
    input  logic            reset,
    tilt_move_gen_if.slave  bus,
    output logic [1:0]      state_dbg
);
    localparam int HB_RAW = (SIMULATE == 1) ? SIMULATE_HALF_PERIOD
                                            : CLK_FREQUENCY_HZ / (2 * BASE_UPDATE_HZ);
    localparam int HB     = (HB_RAW < 1) ? 1 : HB_RAW;
    localparam int HB2    = ((HB >> 1) < 1) ? 1 : (HB >> 1);
    localparam int HB4    = ((HB >> 2) < 1) ? 1 : (HB >> 2);
    localparam int CW     = $clog2(HB + 1);

    localparam logic [CW-1:0] HP_BASE = CW'(HB);
    localparam logic [CW-1:0] HP_HALF = CW'(HB2);
    localparam logic [CW-1:0] HP_QTR  = CW'(HB4);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_MOVING = 2'd2;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    movement_q, movement_d;
    logic [1:0]    tilt_level_q, tilt_level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          update_q, update_d;

    logic [6:0]    ax, ay, mag;
    int            mag_i;
    logic [3:0]    dir;
    logic [1:0]    level;
    logic [CW-1:0] hp;

    // -128 has no positive 8-bit counterpart, so it saturates to 127.
    function automatic logic [6:0] abs_sat(input logic [7:0] v);
        logic [7:0] neg;
        neg = 8'd0 - v;
        if (v == 8'h80)
            return 7'd127;
        else if (v[7])
            return neg[6:0];
        else
            return v[6:0];
    endfunction

    always_comb begin
        ax    = abs_sat(bus.accel_x);
        ay    = abs_sat(bus.accel_y);
        mag   = (ax >= ay) ? ax : ay;
        mag_i = int'(mag);
        dir   = DIR_NONE;
        level = 2'd0;
        if (mag_i > DEADZONE) begin
            // Ties go to the X axis so a diagonal never produces two bits.
            if (ax >= ay)
                dir = (!bus.accel_x[7] && bus.accel_x != 8'd0) ? DIR_RIGHT : DIR_LEFT;
            else
                dir = (!bus.accel_y[7] && bus.accel_y != 8'd0) ? DIR_DOWN : DIR_UP;
            if (mag_i <= 2 * DEADZONE)
                level = 2'd1;
            else if (mag_i <= 4 * DEADZONE)
                level = 2'd2;
            else
                level = 2'd3;
        end
    end

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        movement_d   = movement_q;
        tilt_level_d = tilt_level_q;
        if (bus.sample_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (dir != DIR_NONE) begin
                        state_d = S_ARMED;
                        cand_d  = dir;
                    end
                end
                S_ARMED: begin
                    if (dir == DIR_NONE) begin
                        state_d = S_IDLE;
                    end else if (dir == cand_q) begin
                        state_d      = S_MOVING;
                        movement_d   = dir;
                        tilt_level_d = level;
                    end else begin
                        cand_d = dir;
                    end
                end
                S_MOVING: begin
                    if (dir == movement_q) begin
                        tilt_level_d = level;
                    end else if (dir == DIR_NONE) begin
                        state_d      = S_IDLE;
                        movement_d   = DIR_NONE;
                        tilt_level_d = 2'd0;
                    end else begin
                        state_d      = S_ARMED;
                        cand_d       = dir;
                        movement_d   = DIR_NONE;
                        tilt_level_d = 2'd0;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    movement_d   = DIR_NONE;
                    tilt_level_d = 2'd0;
                end
            endcase
        end
    end

    // The >= compare cuts a half-period short when the level rises mid-count.
    always_comb begin
        case (tilt_level_q)
            2'd2:    hp = HP_HALF;
            2'd3:    hp = HP_QTR;
            default: hp = HP_BASE;
        endcase
        cnt_d    = cnt_q + 1'b1;
        update_d = update_q;
        if (cnt_q >= hp - 1'b1) begin
            cnt_d    = '0;
            update_d = ~update_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cand_q       <= DIR_NONE;
            movement_q   <= DIR_NONE;
            tilt_level_q <= 2'd0;
            cnt_q        <= '0;
            update_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            movement_q   <= movement_d;
            tilt_level_q <= tilt_level_d;
            cnt_q        <= cnt_d;
            update_q     <= update_d;
        end
    end

    assign bus.movement   = movement_q;
    assign bus.tilt_level = tilt_level_q;
    assign bus.update     = update_q;
    assign state_dbg      = state_q;
endmodule
